// File: rtl/pcode_correlator_pkg.sv
// rtl/pcode_correlator_pkg.sv - shared lock-state type and chip product helper
package pcode_correlator_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

    // Hard chips use 0=+1, 1=-1, so equal chips multiply to +1.
    function automatic logic [1:0] chip_prod(input logic chip, input logic tap);
        return (chip == tap) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pcode_corr_tap.sv
// rtl/pcode_corr_tap.sv - single-tap integrate-and-dump accumulator
module pcode_corr_tap
    import pcode_correlator_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dump,
    input  logic                 chip,
    input  logic                 tap,
    output logic [ACC_WIDTH-1:0] sum,
    output logic [ACC_WIDTH-1:0] corr
);

    logic [ACC_WIDTH-1:0] acc;
    logic [1:0]           prod;

    // sum includes the current chip so the dump captures the final product.
    always_comb begin
        prod = chip_prod(chip, tap);
        sum  = acc + {{(ACC_WIDTH-2){prod[1]}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            corr <= '0;
        end else if (en) begin
            if (dump) begin
                corr <= sum;
                acc  <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/pcode_correlator.sv
// rtl/pcode_correlator.sv - early/prompt/late P-code correlator with lock FSM
module pcode_correlator
    import pcode_correlator_pkg::*;
#(
    parameter int INT_LEN    = 1024,
    parameter int ACC_WIDTH  = 16,
    parameter int VERIFY_CNT = 4,
    parameter int MISS_CNT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prn_changed,
    input  logic                 en,
    input  logic                 chip_in,
    input  logic                 code_in,
    input  logic [ACC_WIDTH-1:0] thresh,
    output logic [ACC_WIDTH-1:0] corr_e,
    output logic [ACC_WIDTH-1:0] corr_p,
    output logic [ACC_WIDTH-1:0] corr_l,
    output logic                 corr_valid,
    output logic                 code_slip,
    output logic                 locked,
    output logic [1:0]           lock_state
);

    localparam int CW    = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
    localparam int CNT_MAX = (VERIFY_CNT > MISS_CNT) ? VERIFY_CNT : MISS_CNT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    logic                 rst;
    logic [CW-1:0]        chip_cnt;
    logic [1:0]           code_dl;
    logic                 dump;
    logic [ACC_WIDTH-1:0] sum_e, sum_p, sum_l;
    logic [ACC_WIDTH-1:0] mag_p;
    logic                 hit;

    lock_state_t          state, state_nxt;
    logic [CNT_W-1:0]     hit_cnt, hit_cnt_nxt;
    logic [CNT_W-1:0]     miss_cnt, miss_cnt_nxt;
    logic                 slip_nxt;

    assign rst  = reset | prn_changed;
    assign dump = en && (chip_cnt == CW'(INT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_cnt <= '0;
            code_dl  <= '0;
        end else if (en) begin
            chip_cnt <= dump ? '0 : chip_cnt + CW'(1);
            code_dl  <= {code_dl[0], code_in};
        end
    end

    pcode_corr_tap #(.ACC_WIDTH(ACC_WIDTH)) u_tap_e (
        .clk(clk), .rst(rst), .en(en), .dump(dump),
        .chip(chip_in), .tap(code_in), .sum(sum_e), .corr(corr_e)
    );

    pcode_corr_tap #(.ACC_WIDTH(ACC_WIDTH)) u_tap_p (
        .clk(clk), .rst(rst), .en(en), .dump(dump),
        .chip(chip_in), .tap(code_dl[0]), .sum(sum_p), .corr(corr_p)
    );

    pcode_corr_tap #(.ACC_WIDTH(ACC_WIDTH)) u_tap_l (
        .clk(clk), .rst(rst), .en(en), .dump(dump),
        .chip(chip_in), .tap(code_dl[1]), .sum(sum_l), .corr(corr_l)
    );

    // Inverted data still indicates alignment, so the hit test uses magnitude.
    always_comb begin
        mag_p = sum_p[ACC_WIDTH-1] ? (~sum_p + ACC_WIDTH'(1)) : sum_p;
        hit   = (mag_p >= thresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SEARCH;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            code_slip  <= 1'b0;
            corr_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            hit_cnt    <= hit_cnt_nxt;
            miss_cnt   <= miss_cnt_nxt;
            code_slip  <= slip_nxt;
            corr_valid <= dump;
        end
    end

    always_comb begin
        state_nxt    = state;
        hit_cnt_nxt  = hit_cnt;
        miss_cnt_nxt = miss_cnt;
        slip_nxt     = 1'b0;
        if (dump) begin
            case (state)
                ST_SEARCH: begin
                    if (hit) begin
                        if (VERIFY_CNT <= 1) begin
                            state_nxt    = ST_LOCKED;
                            miss_cnt_nxt = '0;
                        end else begin
                            state_nxt   = ST_VERIFY;
                            hit_cnt_nxt = CNT_W'(1);
                        end
                    end else begin
                        slip_nxt = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (hit) begin
                        hit_cnt_nxt = hit_cnt + CNT_W'(1);
                        if (hit_cnt + CNT_W'(1) == CNT_W'(VERIFY_CNT)) begin
                            state_nxt    = ST_LOCKED;
                            miss_cnt_nxt = '0;
                        end
                    end else begin
                        state_nxt   = ST_SEARCH;
                        hit_cnt_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (hit) begin
                        miss_cnt_nxt = '0;
                    end else if (miss_cnt + CNT_W'(1) == CNT_W'(MISS_CNT)) begin
                        state_nxt    = ST_SEARCH;
                        miss_cnt_nxt = '0;
                        hit_cnt_nxt  = '0;
                    end else begin
                        miss_cnt_nxt = miss_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt    = ST_SEARCH;
                    hit_cnt_nxt  = '0;
                    miss_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked     = (state == ST_LOCKED);
        lock_state = state;
    end

endmodule

// File: tb/tb_pcode_correlator.sv
// tb/tb_pcode_correlator.sv - directed self-checking bench for pcode_correlator
module tb_pcode_correlator;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          prn_changed;
    logic          en;
    logic          chip_in;
    logic          code_in;
    logic [AW-1:0] thresh;
    logic [AW-1:0] corr_e, corr_p, corr_l;
    logic          corr_valid;
    logic          code_slip;
    logic          locked;
    logic [1:0]    lock_state;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int slip_cnt = 0;
    int v0;
    logic prev_code = 1'b0;
    logic code_ph = 1'b0;

    always #5 clk = ~clk;

    pcode_correlator #(
        .INT_LEN(16), .ACC_WIDTH(AW), .VERIFY_CNT(2), .MISS_CNT(3)
    ) dut (
        .clk(clk), .reset(reset), .prn_changed(prn_changed), .en(en),
        .chip_in(chip_in), .code_in(code_in), .thresh(thresh),
        .corr_e(corr_e), .corr_p(corr_p), .corr_l(corr_l),
        .corr_valid(corr_valid), .code_slip(code_slip),
        .locked(locked), .lock_state(lock_state)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic r);
        en = e; chip_in = c; code_in = r;
        @(posedge clk);
        #1;
        if (corr_valid) valid_cnt++;
        if (code_slip) slip_cnt++;
    endtask

    // mode 0: chip = replica delayed one chip; 1: chip held 0; 2: inverted aligned
    task automatic strobe(input int mode);
        logic c;
        case (mode)
            0:       c = prev_code;
            1:       c = 1'b0;
            default: c = ~prev_code;
        endcase
        step(1'b1, c, code_ph);
        prev_code = code_ph;
        code_ph   = ~code_ph;
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) strobe(mode);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic chk_corr(input string tag, input int e, input int p, input int l);
        chk({tag, "_e"}, 32'($signed(corr_e)), e);
        chk({tag, "_p"}, 32'($signed(corr_p)), p);
        chk({tag, "_l"}, 32'($signed(corr_l)), l);
    endtask

    initial begin
        reset = 1'b1; prn_changed = 1'b0; en = 1'b0;
        chip_in = 1'b0; code_in = 1'b0; thresh = 16'd12;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_valid", 32'(corr_valid), 0);
        chk("rst_slip", 32'(code_slip), 0);
        chk("rst_state", 32'(lock_state), 0);
        chk("rst_locked", 32'(locked), 0);
        chk_corr("rst", 0, 0, 0);
        reset = 1'b0;

        // acquisition: first period sees the reset zeros in the delay line
        v0 = valid_cnt;
        run(0, 15);
        chk("d1_no_early_valid", valid_cnt, v0);
        run(0, 1);
        chk("d1_valid", 32'(corr_valid), 1);
        chk_corr("d1", -14, 16, -12);
        chk("d1_state", 32'(lock_state), 1);
        idle();
        chk("d1_valid_pulse", 32'(corr_valid), 0);
        chk("d1_hold_p", 32'($signed(corr_p)), 16);
        run(0, 16);
        chk("d2_valid", 32'(corr_valid), 1);
        chk_corr("d2", -16, 16, -16);
        chk("d2_state", 32'(lock_state), 2);
        chk("d2_locked", 32'(locked), 1);
        chk("acq_no_slip", slip_cnt, 0);

        // loss of lock: 2 misses, inverted hit, then 3 misses
        run(1, 16);
        chk_corr("miss1", 0, 0, 0);
        chk("miss1_state", 32'(lock_state), 2);
        run(1, 16);
        chk("miss2_state", 32'(lock_state), 2);
        run(2, 16);
        chk_corr("inv", 16, -16, 16);
        chk("inv_state", 32'(lock_state), 2);
        run(1, 16);
        chk("m1_state", 32'(lock_state), 2);
        run(1, 16);
        chk("m2_state", 32'(lock_state), 2);
        run(1, 16);
        chk("m3_state", 32'(lock_state), 0);
        chk("m3_locked", 32'(locked), 0);
        chk("m3_slip", 32'(code_slip), 0);
        chk("loss_no_slip", slip_cnt, 0);

        // search slips
        run(1, 16);
        chk("s1_valid", 32'(corr_valid), 1);
        chk("s1_slip", 32'(code_slip), 1);
        chk("s1_p", 32'($signed(corr_p)), 0);
        chk("s1_state", 32'(lock_state), 0);
        idle();
        chk("s1_slip_pulse", 32'(code_slip), 0);
        run(1, 16);
        chk("s2_slip", 32'(code_slip), 1);
        chk("slip_count", slip_cnt, 2);

        // stalls: en 1,0,0 with garbage on idle cycles
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        prev_code = 1'b0; code_ph = 1'b0;
        chk("st_rst_state", 32'(lock_state), 0);
        chk("st_rst_p", 32'($signed(corr_p)), 0);
        v0 = valid_cnt;
        for (int i = 0; i < 15; i++) begin
            strobe(0); idle(); idle();
        end
        chk("st1_no_early_valid", valid_cnt, v0);
        strobe(0);
        chk("st1_valid", 32'(corr_valid), 1);
        chk_corr("st1", -14, 16, -12);
        chk("st1_state", 32'(lock_state), 1);
        for (int i = 0; i < 16; i++) begin
            idle(); idle(); strobe(0);
        end
        chk_corr("st2", -16, 16, -16);
        chk("st2_state", 32'(lock_state), 2);

        // restart at chip 9 discards the partial period
        v0 = valid_cnt;
        run(0, 9);
        prn_changed = 1'b1;
        strobe(0);
        prn_changed = 1'b0;
        chk("rs_state", 32'(lock_state), 0);
        chk("rs_locked", 32'(locked), 0);
        chk("rs_valid", 32'(corr_valid), 0);
        chk_corr("rs", 0, 0, 0);
        run(0, 15);
        chk("rs_no_partial_valid", valid_cnt, v0);
        run(0, 1);
        chk("rs_dump_valid", 32'(corr_valid), 1);
        chk_corr("rs_dump", -16, 14, -14);
        chk("rs_dump_state", 32'(lock_state), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
